aes_core_sched: RTL and testbench

Request scheduler for the shared 256-bit-key AES CTR core (`aes_AESTop`).
- Arbitrates up to NUM_REQ requesters with round-robin priority and latches the winner's plaintext and key.
- Starts the core by pulsing its reset, then enables it until `done_o`.
- Captures the result and returns it on a single tagged response channel, with a watchdog against a hung core.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_rr_arbiter.sv | 33 +++
 rtl/aes_core_sched.sv | 170 +++++++++++++++++
 tb/tb_aes_core_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES CTR core request scheduler.
package aes_pkg;

   localparam int unsigned AES_BLK_W = 128;
   localparam int unsigned AES_KEY_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      CLR,
      RUN,
      RESP
   } sched_state_e;

   typedef struct packed {
      logic [AES_BLK_W-1:0] plaintext;
      logic [AES_KEY_W-1:0] key;
   } aes_req_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr_i wins.
module aes_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
   input  logic                       en_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o
);

   localparam int unsigned IdW = $clog2(NUM_REQ);

   always_comb begin
      int unsigned j;
      logic        found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      if (en_i) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(rr_ptr_i) + i) % NUM_REQ;
            if (!found && req_i[j]) begin
               gnt_o[j] = 1'b1;
               idx_o    = IdW'(j);
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/aes_core_sched.sv
// Round-robin request scheduler for the shared AES CTR core: clear, run with
// watchdog, then return the result on one tagged response channel.
module aes_core_sched
   import aes_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned CLR_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   input  logic [NUM_REQ*AES_BLK_W-1:0]   req_plaintext_i,
   input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key_i,
   output logic                           resp_valid_o,
   input  logic                           resp_ready_i,
   output logic [AES_BLK_W-1:0]           resp_data_o,
   output logic [$clog2(NUM_REQ)-1:0]     resp_id_o,
   output logic                           resp_err_o,
   output logic                           core_rst_n_o,
   output logic                           core_en_o,
   output logic [AES_BLK_W-1:0]           core_plaintext_o,
   output logic [AES_KEY_W-1:0]           core_key_o,
   input  logic                           core_done_i,
   input  logic [AES_BLK_W-1:0]           core_ciphertext_i
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned ClrW = $clog2(CLR_CYCLES + 1);
   localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

   sched_state_e         state_q, state_d;
   logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]       id_q, id_d;
   aes_req_t             req_q, req_d;
   logic [ClrW-1:0]      clr_cnt_q, clr_cnt_d;
   logic [WdW-1:0]       wdog_q, wdog_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [AES_BLK_W-1:0] resp_data_q, resp_data_d;
   logic                 resp_err_q, resp_err_d;
   logic                 core_rst_n_q, core_rst_n_d;
   logic                 core_en_q, core_en_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [IdW-1:0]       gnt_idx;
   aes_req_t             sel_req;

   aes_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i    (req_valid_i),
      .rr_ptr_i (rr_ptr_q),
      .en_i     ((state_q == IDLE) && rst_n),
      .gnt_o    (gnt),
      .idx_o    (gnt_idx)
   );

   assign req_ready_o = gnt;

   always_comb begin
      sel_req = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_req.plaintext = req_plaintext_i[i*AES_BLK_W +: AES_BLK_W];
            sel_req.key       = req_key_i[i*AES_KEY_W +: AES_KEY_W];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      req_d        = req_q;
      clr_cnt_d    = clr_cnt_q;
      wdog_d       = wdog_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      core_rst_n_d = core_rst_n_q;
      core_en_d    = core_en_q;
      unique case (state_q)
         IDLE: begin
            if (|gnt) begin
               req_d        = sel_req;
               id_d         = gnt_idx;
               rr_ptr_d     = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
               clr_cnt_d    = '0;
               core_rst_n_d = 1'b0;
               core_en_d    = 1'b0;
               state_d      = CLR;
            end
         end
         CLR: begin
            if (clr_cnt_q == ClrW'(CLR_CYCLES - 1)) begin
               wdog_d       = '0;
               core_rst_n_d = 1'b1;
               core_en_d    = 1'b1;
               state_d      = RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         RUN: begin
            // done takes priority over a watchdog expiry in the same cycle
            if (core_done_i) begin
               resp_data_d  = core_ciphertext_i;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               core_en_d    = 1'b0;
               state_d      = RESP;
            end else if (wdog_q == WdW'(TIMEOUT)) begin
               resp_data_d  = '0;
               resp_err_d   = 1'b1;
               resp_valid_d = 1'b1;
               core_en_d    = 1'b0;
               state_d      = RESP;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         req_q        <= '0;
         clr_cnt_q    <= '0;
         wdog_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         core_rst_n_q <= 1'b0;
         core_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         req_q        <= req_d;
         clr_cnt_q    <= clr_cnt_d;
         wdog_q       <= wdog_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         core_rst_n_q <= core_rst_n_d;
         core_en_q    <= core_en_d;
      end
   end

   assign resp_valid_o     = resp_valid_q;
   assign resp_data_o      = resp_data_q;
   assign resp_id_o        = id_q;
   assign resp_err_o       = resp_err_q;
   assign core_rst_n_o     = core_rst_n_q;
   assign core_en_o        = core_en_q;
   assign core_plaintext_o = req_q.plaintext;
   assign core_key_o       = req_q.key;

endmodule

// File: tb/tb_aes_core_sched.sv
// Directed/randomised bench for aes_core_sched with a behavioural AES core model.
module tb_aes_core_sched;
   import aes_pkg::*;

   localparam int NREQ = 2;
   localparam int CLR  = 2;
   localparam int TMO  = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [127:0]   pt [NREQ];
   logic [255:0]   key [NREQ];
   logic [255:0]   pt_flat;
   logic [511:0]   key_flat;
   logic           resp_valid;
   logic           resp_ready;
   logic [127:0]   resp_data;
   logic [0:0]     resp_id;
   logic           resp_err;
   logic           core_rst_n;
   logic           core_en;
   logic [127:0]   core_pt;
   logic [255:0]   core_key;
   logic           core_done;
   logic [127:0]   core_ct;

   assign pt_flat  = {pt[1], pt[0]};
   assign key_flat = {key[1], key[0]};

   aes_core_sched #(
      .NUM_REQ    (NREQ),
      .CLR_CYCLES (CLR),
      .TIMEOUT    (TMO)
   ) dut (
      .clk_i             (clk),
      .rst_n             (rst_n),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_plaintext_i   (pt_flat),
      .req_key_i         (key_flat),
      .resp_valid_o      (resp_valid),
      .resp_ready_i      (resp_ready),
      .resp_data_o       (resp_data),
      .resp_id_o         (resp_id),
      .resp_err_o        (resp_err),
      .core_rst_n_o      (core_rst_n),
      .core_en_o         (core_en),
      .core_plaintext_o  (core_pt),
      .core_key_o        (core_key),
      .core_done_i       (core_done),
      .core_ciphertext_i (core_ct)
   );

   // Core model: done from the done_at-th enabled cycle after reset release.
   int cyc     = 0;
   int done_at = 15;
   int en_cnt  = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      if (!core_rst_n) en_cnt <= 0;
      else if (core_en) en_cnt <= en_cnt + 1;
   end
   assign core_done = core_rst_n && core_en && (en_cnt + 1 >= done_at);
   assign core_ct   = core_key[127:0];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int rr     = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [1:0] m, input int p);
      for (int i = 0; i < NREQ; i++) if (m[(p + i) % NREQ]) return (p + i) % NREQ;
      return -1;
   endfunction

   task automatic rand_port(input int p);
      for (int k = 0; k < 4; k++) pt[p][k*32 +: 32] = $urandom();
      for (int k = 0; k < 8; k++) key[p][k*32 +: 32] = $urandom();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_valid"}, resp_valid, 0);
      chk({tag, "_data"}, resp_data, 0);
      chk({tag, "_id"}, resp_id, 0);
      chk({tag, "_err"}, resp_err, 0);
      chk({tag, "_core_rst_n"}, core_rst_n, 0);
      chk({tag, "_core_en"}, core_en, 0);
      chk({tag, "_core_pt"}, core_pt, 0);
      chk({tag, "_core_key"}, core_key, 0);
   endtask

   task automatic wait_accept(input logic [1:0] mask, output int a, output int gid,
                              output bit got);
      logic [1:0] exp_rdy;
      req_valid = mask;
      #1;
      got = 1'b0;
      a   = 0;
      gid = 0;
      for (int i = 0; i < 60; i++) begin
         if (|req_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      chk("accept_seen", got, 1);
      if (!got) return;
      a       = cyc;
      gid     = pick(mask, rr);
      exp_rdy = 2'(1 << gid);
      chk("grant", req_ready, exp_rdy);
      rr = (gid + 1) % NREQ;
   endtask

   task automatic do_job(input logic [1:0] mask, input int d_at, input int stall);
      int a, gid, k;
      bit got, quiet, stable, exp_err;
      logic [127:0] exp_pt, exp_data;
      logic [255:0] exp_key;
      done_at = d_at;
      wait_accept(mask, a, gid, got);
      if (!got) return;
      exp_pt   = pt[gid];
      exp_key  = key[gid];
      exp_err  = (d_at - 1 > TMO);
      k        = exp_err ? TMO : d_at - 1;
      exp_data = exp_err ? 128'h0 : exp_key[127:0];
      @(negedge clk);
      rand_port(gid);
      #1;
      chk("core_plaintext", core_pt, exp_pt);
      chk("core_key", core_key, exp_key);
      chk("core_rst_in_clr", core_rst_n, 0);
      quiet = 1'b1;
      got   = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
         if (|req_ready) quiet = 1'b0;
         @(negedge clk);
         #1;
      end
      chk("resp_seen", got, 1);
      if (!got) return;
      chk("ready_quiet_busy", quiet, 1);
      chk("latency", cyc - a, CLR + k + 2);
      chk("resp_data", resp_data, exp_data);
      chk("resp_id", resp_id, gid);
      chk("resp_err", resp_err, exp_err);
      chk("core_en_resp", core_en, 0);
      if (stall > 0) begin
         stable = 1'b1;
         for (int s = 0; s < stall; s++) begin
            if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_id !== 1'(gid) ||
                resp_err !== exp_err || core_en !== 1'b0 || req_ready !== 2'b00)
               stable = 1'b0;
            @(negedge clk);
            #1;
         end
         chk("stall_hold", stable, 1);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      #1;
      chk("resp_drop", resp_valid, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a, gid;
      bit got, quiet;
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      resp_ready = 1'b0;
      rand_port(0);
      rand_port(1);
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // single request on port 0
      key[0][127:0] = 128'h00112233445566778899AABBCCDDEEFF;
      do_job(2'b01, 15, 0);
      req_valid = 2'b00;

      // both ports valid from reset: alternating grants, one with backpressure
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rr    = 0;
      do_job(2'b11, $urandom_range(1, 30), 0);
      do_job(2'b11, $urandom_range(1, 30), 0);
      do_job(2'b11, 15, 10);
      do_job(2'b11, $urandom_range(1, 30), 0);
      req_valid = 2'b00;

      // watchdog, then done just before and exactly at expiry
      do_job(2'b10, 100000, 0);
      req_valid = 2'b00;
      do_job(2'b01, TMO, 0);
      req_valid = 2'b00;
      do_job(2'b01, TMO + 1, 0);
      req_valid = 2'b00;

      // reset in the middle of RUN
      done_at = 100000;
      wait_accept(2'b01, a, gid, got);
      @(negedge clk);
      req_valid = 2'b00;
      repeat (5) @(negedge clk);
      #1;
      chk("core_en_run", core_en, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_outputs("midrun");
      rr    = 0;
      quiet = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (resp_valid) quiet = 1'b0;
         @(negedge clk);
         #1;
      end
      chk("no_resp_after_reset", quiet, 1);
      do_job(2'b11, 15, 0);
      req_valid = 2'b00;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
